// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_st_t;

  localparam int unsigned DW_DEF       = 32;
  localparam int unsigned AW_DEF       = 8;
  localparam int unsigned LOCK_MAX_DEF = 8;
  localparam int unsigned LCNT_W       = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both master ports and the data-memory side of the arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 8
);
  logic          req0, we0, lock0, gnt0, rvalid0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0, rdata0;

  logic          req1, we1, lock1, gnt1, rvalid1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1, rdata1;

  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_din;
  logic          mem_mwrite, mem_mread;
  logic [DW-1:0] mem_dout;

  // Arbiter view: serves both masters, drives the memory.
  modport slave (
    input  req0, we0, lock0, addr0, wdata0,
    input  req1, we1, lock1, addr1, wdata1,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_a, mem_din, mem_mwrite, mem_mread,
    input  mem_dout
  );

  // Environment view: masters plus the memory instance.
  modport master (
    output req0, we0, lock0, addr0, wdata0,
    output req1, we1, lock1, addr1, wdata1,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_a, mem_din, mem_mwrite, mem_mread,
    output mem_dout
  );
endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick; the port that did not win last is preferred.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_onehot_o,
  output logic       gid_o
);

  always_comb begin
    gnt_onehot_o = 2'b00;
    gid_o        = 1'b0;
    unique case (req_i)
      2'b01: begin gnt_onehot_o = 2'b01; gid_o = 1'b0; end
      2'b10: begin gnt_onehot_o = 2'b10; gid_o = 1'b1; end
      2'b11: begin
        if (last_i) begin gnt_onehot_o = 2'b01; gid_o = 1'b0; end
        else        begin gnt_onehot_o = 2'b10; gid_o = 1'b1; end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded lock bursts sharing one data memory between CPU and DMA ports.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  arb_st_t             st_q, st_d;
  logic                last_q, last_d;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic [DW-1:0]       rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;

  logic [1:0]          pick_gnt;
  logic                pick_gid;
  logic [1:0]          gnt_c;
  logic                gid_c;
  logic                eff_lock_c;
  logic                g_we_c, g_lock_c;
  logic [LCNT_W:0]     lcnt_inc_c;

  rr_pick2 u_pick (
    .req_i        ({bus.req1, bus.req0}),
    .last_i       (last_q),
    .gnt_onehot_o (pick_gnt),
    .gid_o        (pick_gid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= ARB;
      last_q    <= 1'b1;
      lcnt_q    <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      last_q    <= last_d;
      lcnt_q    <= lcnt_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  always_comb begin
    st_d           = st_q;
    last_d         = last_q;
    lcnt_d         = lcnt_q;
    rdata0_d       = rdata0_q;
    rdata1_d       = rdata1_q;
    rvalid0_d      = 1'b0;
    rvalid1_d      = 1'b0;
    gnt_c          = 2'b00;
    gid_c          = PORT_CPU;
    eff_lock_c     = 1'b0;
    bus.mem_a      = '0;
    bus.mem_din    = '0;
    bus.mem_mwrite = 1'b0;
    bus.mem_mread  = 1'b0;
    lcnt_inc_c     = {1'b0, lcnt_q} + (LCNT_W+1)'(1);

    // A lock only holds while its owner keeps requesting; otherwise fall back to round-robin.
    if (st_q == LOCK0 && bus.req0) begin
      gnt_c      = 2'b01;
      gid_c      = PORT_CPU;
      eff_lock_c = 1'b1;
    end else if (st_q == LOCK1 && bus.req1) begin
      gnt_c      = 2'b10;
      gid_c      = PORT_DMA;
      eff_lock_c = 1'b1;
    end else begin
      gnt_c = pick_gnt;
      gid_c = pick_gid;
    end

    // Reset gates the grant so no write reaches memory while rst_n is low.
    if (!rst_n) gnt_c = 2'b00;

    g_we_c   = (gid_c == PORT_DMA) ? bus.we1   : bus.we0;
    g_lock_c = (gid_c == PORT_DMA) ? bus.lock1 : bus.lock0;

    if (gnt_c != 2'b00) begin
      bus.mem_a      = (gid_c == PORT_DMA) ? bus.addr1  : bus.addr0;
      bus.mem_din    = (gid_c == PORT_DMA) ? bus.wdata1 : bus.wdata0;
      bus.mem_mwrite = g_we_c;
      bus.mem_mread  = !g_we_c;

      last_d = gid_c;
      if (!g_lock_c) begin
        st_d   = ARB;
        lcnt_d = '0;
      end else if (!eff_lock_c) begin
        if (LOCK_MAX == 32'd1) begin
          st_d   = ARB;
          lcnt_d = '0;
        end else begin
          st_d   = (gid_c == PORT_DMA) ? LOCK1 : LOCK0;
          lcnt_d = LCNT_W'(1);
        end
      end else if (lcnt_inc_c == (LCNT_W+1)'(LOCK_MAX)) begin
        st_d   = ARB;
        lcnt_d = '0;
      end else begin
        lcnt_d = lcnt_inc_c[LCNT_W-1:0];
      end
    end else begin
      st_d   = ARB;
      lcnt_d = '0;
    end

    if (gnt_c[0] && !bus.we0) begin
      rvalid0_d = 1'b1;
      rdata0_d  = bus.mem_dout;
    end
    if (gnt_c[1] && !bus.we1) begin
      rvalid1_d = 1'b1;
      rdata1_d  = bus.mem_dout;
    end
  end

  assign bus.gnt0    = gnt_c[0];
  assign bus.gnt1    = gnt_c[1];
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory model, read-return scoreboard and directed arbitration scenarios.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic init_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        pend0, pend1;

  dmem_arbiter_if #(.DW(32), .AW(8)) bus ();

  dmem_arbiter #(.DW(32), .AW(8), .LOCK_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Memory instance model: combinational read, write at the clock edge.
  assign bus.mem_dout = mem[bus.mem_a];
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
    end else if (bus.mem_mwrite) begin
      mem[bus.mem_a] <= bus.mem_din;
    end
  end

  // Monitor: checks memory-side mux, exclusivity and read returns against the scoreboard.
  always @(negedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
      pend0 = 1'b0;
      pend1 = 1'b0;
    end else if (!rst_n) begin
      pend0 = 1'b0;
      pend1 = 1'b0;
      q0.delete();
      q1.delete();
    end else begin
      chk("rvalid0_timing", 32'(bus.rvalid0), 32'(pend0));
      chk("rvalid1_timing", 32'(bus.rvalid1), 32'(pend1));
      if (bus.rvalid0 && q0.size() > 0) chk("rdata0", bus.rdata0, q0.pop_front());
      if (bus.rvalid1 && q1.size() > 0) chk("rdata1", bus.rdata1, q1.pop_front());
      chk("gnt_exclusive", 32'(bus.gnt0 & bus.gnt1), 32'd0);

      pend0 = bus.gnt0 && !bus.we0;
      pend1 = bus.gnt1 && !bus.we1;
      if (pend0) q0.push_back(ref_mem[bus.addr0]);
      if (pend1) q1.push_back(ref_mem[bus.addr1]);

      if (bus.gnt0) begin
        chk("mem_a_p0", 32'(bus.mem_a), 32'(bus.addr0));
        chk("mem_din_p0", bus.mem_din, bus.wdata0);
        chk("mem_wr_rd_p0", 32'({bus.mem_mwrite, bus.mem_mread}), 32'({bus.we0, !bus.we0}));
        if (bus.we0) ref_mem[bus.addr0] = bus.wdata0;
      end else if (bus.gnt1) begin
        chk("mem_a_p1", 32'(bus.mem_a), 32'(bus.addr1));
        chk("mem_din_p1", bus.mem_din, bus.wdata1);
        chk("mem_wr_rd_p1", 32'({bus.mem_mwrite, bus.mem_mread}), 32'({bus.we1, !bus.we1}));
        if (bus.we1) ref_mem[bus.addr1] = bus.wdata1;
      end else begin
        chk("mem_idle", 32'({bus.mem_mwrite, bus.mem_mread}), 32'd0);
        chk("mem_a_idle", 32'(bus.mem_a), 32'd0);
      end
    end
  end

  initial begin
    logic g0, g1;
    rst_n      = 1'b0;
    init_done  = 1'b0;
    bus.req0   = 1'b1; bus.we0 = 1'b1; bus.lock0 = 1'b0;
    bus.addr0  = 8'h05; bus.wdata0 = 32'h1111_1111;
    bus.req1   = 1'b1; bus.we1 = 1'b1; bus.lock1 = 1'b1;
    bus.addr1  = 8'h06; bus.wdata1 = 32'h2222_2222;

    // Reset: requests asserted but everything must stay quiet.
    repeat (2) @(posedge clk);
    init_done = 1'b1;
    @(negedge clk);
    chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
    chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
    chk("rst_rvalid", 32'({bus.rvalid1, bus.rvalid0}), 32'd0);
    chk("rst_rdata0", bus.rdata0, 32'd0);
    chk("rst_rdata1", bus.rdata1, 32'd0);
    chk("rst_mwrite", 32'(bus.mem_mwrite), 32'd0);

    // Alternation: continuous reads from both ports.
    drive_edge();
    rst_n = 1'b1;
    bus.we0 = 1'b0; bus.addr0 = 8'h00;
    bus.we1 = 1'b0; bus.lock1 = 1'b0; bus.addr1 = 8'h80;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("alt_gnt0", 32'(bus.gnt0), 32'(i % 2 == 0));
      chk("alt_gnt1", 32'(bus.gnt1), 32'(i % 2 == 1));
      g0 = bus.gnt0; g1 = bus.gnt1;
      drive_edge();
      if (g0) bus.addr0 = bus.addr0 + 8'd1;
      if (g1) bus.addr1 = bus.addr1 + 8'd1;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    drive_edge();

    // Write then read on port 1, port 0 idle.
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h10; bus.wdata1 = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr_gnt1", 32'(bus.gnt1), 32'd1);
    drive_edge();
    bus.we1 = 1'b0;
    @(negedge clk);
    chk("rd_gnt1", 32'(bus.gnt1), 32'd1);
    drive_edge();
    bus.req1 = 1'b0;
    @(negedge clk);
    chk("wr_rd_valid", 32'(bus.rvalid1), 32'd1);
    chk("wr_rd_data", bus.rdata1, 32'hDEAD_BEEF);
    drive_edge();

    // Make port 0 the last winner so the locked port 1 wins the first burst cycle.
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h20;
    @(negedge clk);
    chk("pre_burst_gnt0", 32'(bus.gnt0), 32'd1);
    drive_edge();

    // Lock burst on port 1 with port 0 requesting throughout.
    bus.addr0 = 8'h21;
    bus.req1 = 1'b1; bus.lock1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h30;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("burst_gnt1", 32'(bus.gnt1), 32'(i < 8));
      chk("burst_gnt0", 32'(bus.gnt0), 32'(i == 8));
      g1 = bus.gnt1;
      drive_edge();
      if (g1) bus.addr1 = bus.addr1 + 8'd1;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock1 = 1'b0;
    drive_edge();

    // Port 1 lone read so port 0 wins the next contended cycle.
    bus.req1 = 1'b1; bus.addr1 = 8'h31;
    @(negedge clk);
    chk("pre_early_gnt1", 32'(bus.gnt1), 32'd1);
    drive_edge();

    // Early release: port 0 drops its locked request after three grants.
    bus.addr1 = 8'h32;
    bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.addr0 = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin bus.req0 = 1'b0; bus.lock0 = 1'b0; end
      @(negedge clk);
      chk("early_gnt0", 32'(bus.gnt0), 32'(i < 3));
      chk("early_gnt1", 32'(bus.gnt1), 32'(i == 3));
      g0 = bus.gnt0;
      drive_edge();
      if (g0) bus.addr0 = bus.addr0 + 8'd1;
    end
    bus.req1 = 1'b0;
    drive_edge();

    // Locked writes on port 1, then reset during the fifth one.
    bus.req1 = 1'b1; bus.lock1 = 1'b1; bus.we1 = 1'b1;
    bus.addr1 = 8'h40; bus.wdata1 = 32'h0000_00A0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lockwr_gnt1", 32'(bus.gnt1), 32'd1);
      drive_edge();
      bus.addr1  = bus.addr1 + 8'd1;
      bus.wdata1 = bus.wdata1 + 32'd1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_gnt1", 32'(bus.gnt1), 32'd0);
    chk("rst_mid_mwrite", 32'(bus.mem_mwrite), 32'd0);
    chk("rst_mid_rvalid", 32'({bus.rvalid1, bus.rvalid0}), 32'd0);
    drive_edge();
    chk("rst_mid_no_write", mem[68], 32'h0000_0044);
    rst_n = 1'b1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h01;
    bus.lock1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 8'h44;
    @(negedge clk);
    chk("resume_gnt0", 32'(bus.gnt0), 32'd1);
    chk("resume_gnt1", 32'(bus.gnt1), 32'd0);
    drive_edge();
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("resume_next_gnt1", 32'(bus.gnt1), 32'd1);
    drive_edge();
    bus.addr1 = 8'h43;
    @(negedge clk);
    chk("readback_gnt1", 32'(bus.gnt1), 32'd1);
    drive_edge();
    bus.req1 = 1'b0;
    @(negedge clk);
    chk("readback_data", bus.rdata1, 32'h0000_00A3);
    repeat (2) drive_edge();

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter that shares the single-ported synchronous data memory (256 × 32, combinational read, write on rising clock edge) between the CPU data port (port 0) and a DMA/debug loader (port 1).
- One memory access is granted per cycle.
- A requester can hold the memory for a bounded burst using `lock`.
- Read data is registered and returned one cycle after the grant.
- The block sits between the two masters and the data memory instance.

## Interface
Parameters:
- `DW`, 32: data width; must match the memory word size.
- `AW`, 8: address width, $clog2(256).
- `LOCK_MAX`, 8: maximum consecutive granted cycles under lock, range 1..255.

Ports (x = 0, 1):
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `reqx`  in  1  access request; held until `gntx` is seen.
- `wex`  in  1  1 = write, 0 = read.
- `addrx`  in  AW  word address.
- `wdatax`  in  DW  write data.
- `lockx`  in  1  request to keep ownership on following cycles.
- `gntx`  out  1  access performed this cycle (combinational).
- `rdatax`  out  DW  registered read data.
- `rvalidx`  out  1  `rdatax` valid, one-cycle pulse.
- `mem_a`  out  AW  memory address.
- `mem_din`  out  DW  memory write data.
- `mem_mwrite`  out  1  memory write enable.
- `mem_mread`  out  1  memory read strobe.
- `mem_dout`  in  DW  memory combinational read data.

## Operation
- State register `st` ∈ {ARB, LOCK0, LOCK1}. Also held: `last` (last-granted port, 1 bit) and `lcnt` (8-bit lock counter).
- Reset values:
  - `st` = ARB, `last` = 1 (so port 0 wins first), `lcnt` = 0.
  - `rdata0/1` = 0, `rvalid0/1` = 0.
  - Memory-side outputs are combinational; they are 0 when no grant is given.
- Effective state: LOCKx with `reqx` = 0 is treated as ARB for the current cycle, so the other port may be granted in that same cycle.
- ARB:
  - Only one port requesting: that port is granted.
  - Both requesting: the port ≠ `last` is granted.
  - Neither requesting: no grant.
- LOCKx with `reqx` = 1: only port x is granted; the other port waits even if requesting.
- Granted port g drives `mem_a = addrg`, `mem_din = wdatag`, `mem_mwrite = weg`, `mem_mread = !weg`. Ungranted: all memory-side outputs are 0.
- `gnt0` and `gnt1` are never both 1.
- Next-state rules on a grant to g, applied in this order:
  - `last` ← g.
  - If `lockg` = 0: `st` ← ARB, `lcnt` ← 0.
  - Else if the effective state was ARB: `st` ← LOCKg, `lcnt` ← 1.
  - Else if `lcnt` + 1 == LOCK_MAX: `st` ← ARB, `lcnt` ← 0 (forced release).
  - Else: `lcnt` ← `lcnt` + 1.
- LOCK_MAX = 1 means `lock` never holds ownership: every grant with lock = 1 goes straight to ARB.
- No grant: `st` ← ARB, `lcnt` ← 0, `last` unchanged.
- After a forced release with both ports requesting, `last` = g guarantees the other port wins the next cycle.
- Read return: on a granted read, `rdatag` ← `mem_dout` and `rvalidg` ← 1 at the edge. Otherwise `rvalidx` ← 0, and `rdatax` holds its value.

## Timing
- Grant latency: 0 cycles. `gntx` is combinational from `reqx`, `lockx`, `st` and `last`.
- A requester samples `gntx` at the edge. It may change `addr`/`we`/`wdata` only after a granted edge.
- Write latency: the memory array is updated at the edge ending the grant cycle.
- Read latency: `rvalidx`/`rdatax` are valid in the cycle after the grant. Back-to-back reads give back-to-back `rvalid`.
- Read after write, same address: a read granted in the cycle after the write returns the new data.
- `rst_n` low mid-burst: immediately `st` = ARB and `rvalid` = 0, and no memory write occurs while `rst_n` is low, since the grant is gated by `rst_n`.
- Combinational paths run from `req`/`addr` to `mem_*`. No path from `mem_dout` to `gnt`.

## Structure
- Package `dmem_arb_pkg`:
  - state enum `arb_st_t` {ARB, LOCK0, LOCK1};
  - `LOCK_MAX_DEF` = 8;
  - `PORT_CPU` = 0, `PORT_DMA` = 1.
- Sub-module `rr_pick2`: purely combinational 2-way round-robin pick. Inputs: `req[1:0]`, `last`. Outputs: `gnt_onehot`, `gid`. Lock override, counters and read-return registers stay in the top.

## Test plan
- **Reset:** `rst_n` = 0 → `gnt` = 0, `rvalid` = 0, `rdata` = 0, `mem_mwrite` = 0. First cycle after release with `req0` = `req1` = 1 → `gnt0` = 1.
- **Alternation:** both ports issue continuous reads, no lock, memory preloaded with mem[i] = i. Required:
  - grants alternate 0, 1, 0, 1;
  - each `rvalidx` follows its grant by exactly 1 cycle;
  - `rdata` matches the address.
- **Write then read:** port 1 writes 0xDEADBEEF to address 0x10, then reads 0x10 → `rdata1` = 0xDEADBEEF one cycle after the read grant. Port 0 idle throughout.
- **Lock burst, LOCK_MAX = 8:** `lock1` = 1, `req1` held, `req0` = 1 throughout. Required:
  - `gnt1` for exactly 8 cycles, then `gnt0` on cycle 9;
  - `gnt0` never asserted during the burst.
- **Early lock release:** `lock0` burst where `req0` drops after 3 grants → `gnt1` in the same cycle `req0` drops.
- **Reset mid-lock:** `rst_n` pulsed low during a 5th locked write → no memory write that cycle. After release, arbitration resumes from `last` = 1.
